axi4lite_reg_slave: RTL and testbench

//   Parametrised AXI4-Lite slave register bank: NUM_REGS word registers, per-register read-only masking,

---
 rtl/axi4lite_reg_slave_if.sv | 33 +++
 rtl/axi4lite_reg_slave.sv | 112 +++++++++++
 tb/tb_axi4lite_reg_slave.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_reg_slave_if.sv
// axi4lite_reg_slave_if: AXI4-Lite bus bundle with master and slave views
interface axi4lite_reg_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4lite_reg_slave.sv
// axi4lite_reg_slave: AXI4-Lite CSR bank with byte strobes, read-only status slots and SLVERR decode
module axi4lite_reg_slave #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  axi4lite_reg_slave_if.slave            s,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW  = $clog2(NUM_REGS);
  localparam int NP  = 1 << IW;
  localparam logic [NP-1:0] RO_EXT = NP'(RO_MASK);
  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;
  wstate_t ws, ws_n;
  rstate_t rs, rs_n;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] aw_buf, aw_eff;
  logic [DATA_WIDTH-1:0] w_buf, w_eff, rd_val;
  logic [SW-1:0]         s_buf, s_eff;
  logic [IW-1:0]         w_idx, r_idx;
  logic                  aw_hs, w_hs, ar_hs, commit, w_err, r_err;
  logic                  unused;
  // Index field past NUM_REGS or any set bit above it is a decode miss.
  function automatic logic oor(input logic [ADDR_WIDTH-1:0] a);
    return int'(a[LSB +: IW]) >= NUM_REGS || |(a >> (LSB + IW));
  endfunction
  assign aw_hs  = s.awvalid && s.awready;
  assign w_hs   = s.wvalid && s.wready;
  assign ar_hs  = s.arvalid && s.arready;
  assign aw_eff = ws == W_HAVE_AW ? aw_buf : s.awaddr;
  assign w_eff  = ws == W_HAVE_W ? w_buf : s.wdata;
  assign s_eff  = ws == W_HAVE_W ? s_buf : s.wstrb;
  assign w_idx  = aw_eff[LSB +: IW];
  assign r_idx  = s.araddr[LSB +: IW];
  assign w_err  = oor(aw_eff) || RO_EXT[w_idx];
  assign r_err  = oor(s.araddr);
  assign commit = ws != W_RESP && ws_n == W_RESP;
  assign unused = ^{s.awprot, s.arprot};
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws <= W_IDLE;
      rs <= R_IDLE;
    end else begin
      ws <= ws_n;
      rs <= rs_n;
    end
  end
  always_comb begin
    ws_n = ws;
    case (ws)
      W_IDLE:    ws_n = aw_hs && w_hs ? W_RESP : aw_hs ? W_HAVE_AW : w_hs ? W_HAVE_W : W_IDLE;
      W_HAVE_AW: ws_n = w_hs ? W_RESP : W_HAVE_AW;
      W_HAVE_W:  ws_n = aw_hs ? W_RESP : W_HAVE_W;
      default:   ws_n = s.bready ? W_IDLE : W_RESP;
    endcase
    rs_n = rs == R_IDLE ? (ar_hs ? R_RESP : R_IDLE) : (s.rready ? R_IDLE : R_RESP);
  end
  always_comb begin
    s.awready = ws == W_IDLE || ws == W_HAVE_W;
    s.wready  = ws == W_IDLE || ws == W_HAVE_AW;
    s.bvalid  = ws == W_RESP;
    s.arready = rs == R_IDLE;
    s.rvalid  = rs == R_RESP;
  end
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (r_idx == IW'(i)) rd_val = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_buf   <= '0;
      w_buf    <= '0;
      s_buf    <= '0;
      wr_pulse <= '0;
      s.bresp  <= 2'b00;
      s.rdata  <= '0;
      s.rresp  <= 2'b00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      wr_pulse <= '0;
      if (aw_hs) aw_buf <= s.awaddr;
      if (w_hs) begin
        w_buf <= s.wdata;
        s_buf <= s.wstrb;
      end
      if (commit) s.bresp <= w_err ? 2'b10 : 2'b00;
      if (ar_hs) begin
        s.rdata <= r_err ? '0 : rd_val;
        s.rresp <= r_err ? 2'b10 : 2'b00;
      end
      for (int i = 0; i < NUM_REGS; i++)
        if (commit && !w_err && w_idx == IW'(i)) begin
          wr_pulse[i] <= 1'b1;
          for (int b = 0; b < SW; b++)
            if (s_eff[b]) regs[i][8*b +: 8] <= w_eff[8*b +: 8];
        end
    end
  end
endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// tb_axi4lite_reg_slave: vector table plus corner sequences, responses checked through queues
module tb_axi4lite_reg_slave;
  logic clk, reset;
  logic [511:0] reg_out, hw_in;
  logic [15:0]  wr_pulse;
  int tests = 0, fails = 0, bcnt = 0, rcnt = 0;
  logic pb = 0, pr = 0;
  logic [17:0] bq [$];
  logic [33:0] rq [$];
  logic [17:0] be;
  logic [33:0] re;
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [15:0] pulse;
  } vec_t;
  vec_t vt [17];
  axi4lite_reg_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s ();
  axi4lite_reg_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .RO_MASK(16'h0001), .RESET_VAL(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .s(s), .reg_out(reg_out), .hw_in(hw_in), .wr_pulse(wr_pulse)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset) begin
      pb = 0;
      pr = 0;
    end else begin
      if (s.bvalid && !pb) begin
        check("b_expected", bq.size() != 0, 1);
        if (bq.size() != 0) begin
          be = bq.pop_front();
          check("bresp", s.bresp, be[17:16]);
          check("wr_pulse", wr_pulse, be[15:0]);
        end
        bcnt++;
      end else check("wr_pulse_idle", wr_pulse, 16'h0);
      if (s.rvalid && !pr) begin
        check("r_expected", rq.size() != 0, 1);
        if (rq.size() != 0) begin
          re = rq.pop_front();
          check("rresp", s.rresp, re[33:32]);
          check("rdata", s.rdata, re[31:0]);
        end
        rcnt++;
      end
      pb = s.bvalid;
      pr = s.rvalid;
    end
  end
  task automatic wait_b(input int n);
    int t = 0;
    while (bcnt < n && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("b_arrived", bcnt >= n, 1);
    @(negedge clk);
  endtask
  task automatic wait_r(input int n);
    int t = 0;
    while (rcnt < n && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("r_arrived", rcnt >= n, 1);
    @(negedge clk);
  endtask
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                          input logic [1:0] r, input logic [15:0] p, input int aw_at, input int w_at);
    int c = 0;
    int n = bcnt + 1;
    bit ad = 0, wd = 0, ah, wh;
    bq.push_back({r, p});
    s.awaddr = a;
    s.wdata  = d;
    s.wstrb  = st;
    while (!(ad && wd) && c < 40) begin
      s.awvalid = !ad && c >= aw_at;
      s.wvalid  = !wd && c >= w_at;
      ah = s.awvalid && s.awready;
      wh = s.wvalid && s.wready;
      @(negedge clk);
      c++;
      ad = ad | ah;
      wd = wd | wh;
    end
    s.awvalid = 0;
    s.wvalid  = 0;
    check("aw_w_accepted", {ad, wd}, 2'b11);
    wait_b(n);
  endtask
  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    int c = 0;
    int n = rcnt + 1;
    bit h = 0;
    rq.push_back({r, d});
    s.araddr = a;
    while (!h && c < 40) begin
      s.arvalid = 1;
      h = s.arready;
      @(negedge clk);
      c++;
    end
    s.arvalid = 0;
    check("ar_accepted", h, 1);
    wait_r(n);
  endtask
  initial begin
    int nb, nr;
    vt[0]  = '{1, 32'h00000008, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        16'h0004};
    vt[1]  = '{0, 32'h00000008, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 16'h0};
    vt[2]  = '{1, 32'h00000004, 32'h12345678, 4'hF, 2'b00, 32'h0,        16'h0002};
    vt[3]  = '{1, 32'h00000004, 32'h000000AA, 4'h1, 2'b00, 32'h0,        16'h0002};
    vt[4]  = '{0, 32'h00000004, 32'h0,        4'h0, 2'b00, 32'h123456AA, 16'h0};
    vt[5]  = '{1, 32'h00000004, 32'hCCDD0000, 4'hC, 2'b00, 32'h0,        16'h0002};
    vt[6]  = '{0, 32'h00000004, 32'h0,        4'h0, 2'b00, 32'hCCDD56AA, 16'h0};
    vt[7]  = '{1, 32'h00000004, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0,        16'h0002};
    vt[8]  = '{0, 32'h00000004, 32'h0,        4'h0, 2'b00, 32'hCCDD56AA, 16'h0};
    vt[9]  = '{1, 32'h00000000, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0,        16'h0};
    vt[10] = '{0, 32'h00000000, 32'h0,        4'h0, 2'b00, 32'h00001234, 16'h0};
    vt[11] = '{1, 32'h00000040, 32'h11111111, 4'hF, 2'b10, 32'h0,        16'h0};
    vt[12] = '{0, 32'h00000040, 32'h0,        4'h0, 2'b10, 32'h0,        16'h0};
    vt[13] = '{0, 32'h80000008, 32'h0,        4'h0, 2'b10, 32'h0,        16'h0};
    vt[14] = '{1, 32'h0000003C, 32'hA5A5A5A5, 4'hF, 2'b00, 32'h0,        16'h8000};
    vt[15] = '{0, 32'h0000003F, 32'h0,        4'h0, 2'b00, 32'hA5A5A5A5, 16'h0};
    vt[16] = '{0, 32'h00000008, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 16'h0};
    hw_in = {512{1'b1}};
    hw_in[31:0] = 32'h00001234;
    {s.awvalid, s.wvalid, s.arvalid} = '0;
    {s.awaddr, s.araddr, s.wdata} = '0;
    s.wstrb = '0;
    s.awprot = '0;
    s.arprot = '0;
    s.bready = 1;
    s.rready = 1;
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("reset_flags", {s.awready, s.wready, s.arready, s.bvalid, s.rvalid}, 5'b11100);
    check("reset_resp", {s.bresp, s.rresp, s.rdata}, 36'h0);
    check("reset_regs", |reg_out, 0);
    for (int i = 0; i < 17; i++)
      if (vt[i].wr) do_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].resp, vt[i].pulse, 0, 0);
      else do_read(vt[i].addr, vt[i].rdata, vt[i].resp);
    check("reg_out0", reg_out[0*32 +: 32], 32'h0);
    check("reg_out1", reg_out[1*32 +: 32], 32'hCCDD56AA);
    check("reg_out2", reg_out[2*32 +: 32], 32'hDEADBEEF);
    check("reg_out15", reg_out[15*32 +: 32], 32'hA5A5A5A5);
    // W three cycles ahead of AW
    bq.push_back({2'b00, 16'h0002});
    nb = bcnt + 1;
    s.bready = 0;
    s.wdata = 32'h000000BB;
    s.wstrb = 4'h1;
    s.wvalid = 1;
    check("w_first_ready", s.wready, 1);
    @(negedge clk);
    s.wvalid = 0;
    check("w_buffered", {s.wready, s.awready}, 2'b01);
    repeat (2) @(negedge clk);
    check("w_still_buffered", s.wready, 0);
    s.awaddr = 32'h4;
    s.awvalid = 1;
    @(negedge clk);
    s.awvalid = 0;
    check("b_hold_ready", {s.bvalid, s.awready, s.wready}, 3'b100);
    repeat (2) @(negedge clk);
    check("b_held", {s.bvalid, s.bresp, s.awready}, 4'b1000);
    s.bready = 1;
    wait_b(nb);
    check("b_done", {s.bvalid, s.awready, s.wready}, 3'b011);
    do_read(32'h4, 32'hCCDD56BB, 2'b00);
    do_write(32'h18, 32'h0000FF00, 4'h2, 2'b00, 16'h0040, 0, 2);
    do_read(32'h18, 32'h0000FF00, 2'b00);
    // read and write commit to the same register on one edge
    bq.push_back({2'b00, 16'h0020});
    rq.push_back({2'b00, 32'h0});
    nb = bcnt + 1;
    nr = rcnt + 1;
    s.awaddr = 32'h14;
    s.araddr = 32'h14;
    s.wdata = 32'h55;
    s.wstrb = 4'hF;
    {s.awvalid, s.wvalid, s.arvalid} = 3'b111;
    check("same_edge_ready", {s.awready, s.wready, s.arready}, 3'b111);
    @(negedge clk);
    {s.awvalid, s.wvalid, s.arvalid} = 3'b000;
    wait_b(nb);
    wait_r(nr);
    do_read(32'h14, 32'h55, 2'b00);
    // responses stall with both ready inputs low
    s.bready = 0;
    s.rready = 0;
    do_write(32'h10, 32'h0F0F0F0F, 4'hF, 2'b00, 16'h0010, 0, 0);
    do_read(32'h8, 32'hDEADBEEF, 2'b00);
    for (int i = 0; i < 10; i++)
      check("stall_hold", {s.bvalid, s.rvalid, s.awready, s.wready, s.arready, s.bresp, s.rresp, s.rdata},
            {5'b11000, 4'b0000, 32'hDEADBEEF});
    s.bready = 1;
    s.rready = 1;
    repeat (2) @(negedge clk);
    check("stall_release", {s.bvalid, s.rvalid, s.awready, s.wready, s.arready}, 5'b00111);
    do_read(32'h10, 32'h0F0F0F0F, 2'b00);
    // reset with W buffered and a read response pending
    s.rready = 0;
    do_read(32'h8, 32'hDEADBEEF, 2'b00);
    s.wdata = 32'h77;
    s.wstrb = 4'hF;
    s.wvalid = 1;
    @(negedge clk);
    s.wvalid = 0;
    check("pre_reset", {s.wready, s.rvalid}, 2'b01);
    reset = 1;
    #1;
    check("in_reset", {s.bvalid, s.rvalid, s.rdata, wr_pulse}, 50'h0);
    for (int i = 0; i < 16; i++) check("reset_reg", reg_out[i*32 +: 32], 32'h0);
    repeat (2) @(negedge clk);
    reset = 0;
    s.rready = 1;
    repeat (5) @(negedge clk);
    check("post_reset", {s.bvalid, s.rvalid, s.awready, s.wready, s.arready}, 5'b00111);
    s.awaddr = 32'h8;
    s.awvalid = 1;
    @(negedge clk);
    s.awvalid = 0;
    repeat (4) @(negedge clk);
    check("stale_w_dropped", {s.bvalid, s.awready, s.wready}, 3'b001);
    bq.push_back({2'b00, 16'h0004});
    nb = bcnt + 1;
    s.wdata = 32'h11223344;
    s.wvalid = 1;
    @(negedge clk);
    s.wvalid = 0;
    wait_b(nb);
    do_read(32'h8, 32'h11223344, 2'b00);
    do_read(32'h4, 32'h0, 2'b00);
    check("bq_empty", bq.size(), 0);
    check("rq_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
